// File: rtl/regfile_access_ctrl.sv
// Two-requester arbiter and access sequencer for a 32x32 register file.
// Serialises reads/writes, drives setup/strobe/hold cycles and returns
// read data or a write acknowledgement to the granted requester.
module regfile_access_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr1,
  input  logic [ADDR_W-1:0] req0_addr2,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr1,
  input  logic [ADDR_W-1:0] req1_addr2,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata1,
  output logic [DATA_W-1:0] rsp_rdata2,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_read,
  output logic              rf_reg_write,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  typedef enum logic [2:0] {
    IDLE, R_ADDR, R_EN, R_RSP, W_SETUP, W_PULSE, W_HOLD
  } state_t;

  state_t state_q, state_d;
  logic   rr_ptr;
  logic   owner_q;
  logic   grant1;
  logic   hs;
  logic   sel_we;
  logic [ADDR_W-1:0] sel_addr1;
  logic [ADDR_W-1:0] sel_addr2;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration, handshake and next-state decode
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    hs         = 1'b0;
    grant1     = req1_valid && (!req0_valid || rr_ptr);
    sel_we     = grant1 ? req1_we    : req0_we;
    sel_addr1  = grant1 ? req1_addr1 : req0_addr1;
    sel_addr2  = grant1 ? req1_addr2 : req0_addr2;
    sel_wdata  = grant1 ? req1_wdata : req0_wdata;
    case (state_q)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          hs         = 1'b1;
          req0_ready = !grant1;
          req1_ready = grant1;
          state_d    = sel_we ? W_SETUP : R_ADDR;
        end
      end
      R_ADDR:  state_d = R_EN;
      R_EN:    state_d = R_RSP;
      R_RSP:   state_d = IDLE;
      // Writes to index 0 skip the strobe so register 0 is never touched
      W_SETUP: state_d = (rf_write_reg == '0) ? W_HOLD : W_PULSE;
      W_PULSE: state_d = W_HOLD;
      W_HOLD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration pointer and owner of the in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= 1'b0;
      owner_q <= 1'b0;
    end else if (hs) begin
      rr_ptr  <= ~grant1;
      owner_q <= grant1;
    end
  end

  // Registered strobes and response pulses, decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_reg_read  <= 1'b0;
      rf_reg_write <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      rf_reg_read  <= (state_d == R_EN);
      rf_reg_write <= (state_d == W_PULSE);
      rsp0_valid   <= (state_d == R_RSP || state_d == W_HOLD) && !owner_q;
      rsp1_valid   <= (state_d == R_RSP || state_d == W_HOLD) && owner_q;
    end
  end

  // Address/data latched at handshake; read data captured leaving R_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rsp_rdata1    <= '0;
      rsp_rdata2    <= '0;
    end else begin
      if (hs) begin
        if (sel_we) begin
          rf_write_reg  <= sel_addr1;
          rf_write_data <= sel_wdata;
        end else begin
          rf_read_reg1 <= sel_addr1;
          rf_read_reg2 <= sel_addr2;
        end
      end
      if (state_q == R_EN) begin
        rsp_rdata1 <= rf_read_data1;
        rsp_rdata2 <= rf_read_data2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with an edge-triggered register file model.
module tb_regfile_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [4:0]  req0_addr1, req0_addr2;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [4:0]  req1_addr1, req1_addr2;
  logic [31:0] req1_wdata;
  logic [31:0] rsp_rdata1, rsp_rdata2;
  logic [4:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_reg_read, rf_reg_write;
  logic [31:0] rf_read_data1, rf_read_data2;

  logic [31:0] rf [0:31];
  int checks = 0;
  int errors = 0;
  int wr_edges = 0;
  int rsp0_cnt = 0;
  int rsp1_cnt = 0;
  int overlap = 0;

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr1(req0_addr1), .req0_addr2(req0_addr2), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr1(req1_addr1), .req1_addr2(req1_addr2), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid),
    .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_read(rf_reg_read), .rf_reg_write(rf_reg_write),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: writes on the rising edge of RegWrite, combinational reads
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
    forever begin
      @(posedge rf_reg_write);
      rf[rf_write_reg] = rf_write_data;
      wr_edges++;
    end
  end
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  // Response pulse counters and strobe exclusivity monitor
  always @(negedge clk) begin
    if (rsp0_valid) rsp0_cnt++;
    if (rsp1_valid) rsp1_cnt++;
    if (rf_reg_read && rf_reg_write) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Drives one request, waits for handshake and response (bounded); -1 marks a timeout
  task automatic txn(input int n, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] wd, output int wait_c, output int lat,
                     output logic [31:0] d1, output logic [31:0] d2);
    wait_c = -1; lat = -1; d1 = '0; d2 = '0;
    if (n == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr1 = a1; req0_addr2 = a2; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr1 = a1; req1_addr2 = a2; req1_wdata = wd;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        wait_c = k;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (wait_c >= 0) begin
      for (int c = 1; c <= 10; c++) begin
        #1;
        if ((n == 0 && rsp0_valid) || (n == 1 && rsp1_valid)) begin
          lat = c; d1 = rsp_rdata1; d2 = rsp_rdata2;
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr1 = 5'd3; req0_addr2 = 5'd4; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr1 = '0; req1_addr2 = '0; req1_wdata = '0;
    step(); step();
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_reg_read, rf_reg_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_reg_read, rf_reg_write});
    end
    checks++;
    if ({rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data, rsp_rdata1, rsp_rdata2} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h/%h exp=0", rf_read_reg1, rf_read_reg2,
               rf_write_reg, rf_write_data, rsp_rdata1, rsp_rdata2);
    end
    req0_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    logic [3:0] ord;
    int gcyc[4];
    int ng, both, rsp0cyc;
    logic [31:0] r0d1;
    ord = '0; ng = 0; both = 0; rsp0cyc = -1; r0d1 = '0;
    for (int i = 0; i < 4; i++) gcyc[i] = -1;
    apply_reset();
    req0_we = 1'b0; req0_addr1 = 5'd1; req0_addr2 = 5'd2;
    req1_we = 1'b0; req1_addr1 = 5'd3; req1_addr2 = 5'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready || req1_ready) begin
        ord[ng] = req1_ready; gcyc[ng] = c; ng++;
      end
      if (rsp0_valid && rsp0cyc < 0) begin rsp0cyc = c; r0d1 = rsp_rdata1; end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (ng != 4 || ord !== 4'b1010) begin
      errors++; $display("FAIL arb_order got=%b grants=%0d exp=1010 grants=4", ord, ng);
    end
    checks++;
    if (gcyc[1] != 4 || gcyc[3] != 12) begin
      errors++; $display("FAIL arb_spacing got=%0d,%0d exp=4,12", gcyc[1], gcyc[3]);
    end
    checks++;
    if (both != 0) begin errors++; $display("FAIL arb_both_ready got=%0d exp=0", both); end
    checks++;
    if (rsp0cyc != 3 || r0d1 !== 32'h101) begin
      errors++; $display("FAIL arb_rsp0 got=cyc%0d data=%h exp=cyc3 data=00000101", rsp0cyc, r0d1);
    end
  endtask

  task automatic test_write_read();
    int e0, w, l;
    logic [31:0] d1, d2;
    e0 = wr_edges;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr1 = 5'd5; req0_addr2 = '0; req0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL wr_ready got=%b%b exp=10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_setup got=%b/%0d/%h exp=0/5/deadbeef", rf_reg_write, rf_write_reg, rf_write_data);
    end
    step(); #1;
    checks++;
    if (rf_reg_write !== 1'b1 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse got=we%b rsp%b exp=we1 rsp0", rf_reg_write, rsp0_valid);
    end
    step(); #1;
    checks++;
    if (rf_reg_write !== 1'b0 || rsp0_valid !== 1'b1 || rf_write_reg !== 5'd5) begin
      errors++; $display("FAIL wr_hold got=we%b rsp%b reg%0d exp=we0 rsp1 reg5", rf_reg_write, rsp0_valid, rf_write_reg);
    end
    step();
    checks++;
    if (rf[5] !== 32'hDEADBEEF || wr_edges != e0 + 1) begin
      errors++; $display("FAIL wr_commit got=%h edges=%0d exp=deadbeef edges=%0d", rf[5], wr_edges, e0 + 1);
    end
    txn(0, 1'b0, 5'd5, 5'd0, 32'h0, w, l, d1, d2);
    checks++;
    if (w != 0 || l != 3 || d1 !== 32'hDEADBEEF || d2 !== 32'h0) begin
      errors++; $display("FAIL rd_after_wr got=w%0d l%0d %h %h exp=w0 l3 deadbeef 00000000", w, l, d1, d2);
    end
  endtask

  task automatic test_write_r0();
    int e0, w, l;
    logic [31:0] d1, d2;
    e0 = wr_edges;
    txn(1, 1'b1, 5'd0, 5'd0, 32'h12345678, w, l, d1, d2);
    checks++;
    if (w != 0 || l != 2) begin
      errors++; $display("FAIL wr_r0_ack got=w%0d l%0d exp=w0 l2", w, l);
    end
    checks++;
    if (wr_edges != e0 || rf[0] !== 32'h0) begin
      errors++; $display("FAIL wr_r0_strobe got=edges%0d r0=%h exp=edges%0d r0=0", wr_edges, rf[0], e0);
    end
    txn(1, 1'b0, 5'd0, 5'd0, 32'h0, w, l, d1, d2);
    checks++;
    if (l != 3 || d1 !== 32'h0) begin
      errors++; $display("FAIL rd_r0 got=l%0d %h exp=l3 00000000", l, d1);
    end
  endtask

  task automatic test_back_to_back();
    int w, l;
    logic [31:0] d1, d2;
    txn(0, 1'b1, 5'd31, 5'd0, 32'h1, w, l, d1, d2);
    checks++;
    if (l != 3) begin errors++; $display("FAIL b2b_wr got=l%0d exp=l3", l); end
    txn(0, 1'b0, 5'd31, 5'd30, 32'h0, w, l, d1, d2);
    checks++;
    if (w != 0 || l != 3 || d1 !== 32'h1 || d2 !== 32'h11E) begin
      errors++; $display("FAIL b2b_rd got=w%0d l%0d %h %h exp=w0 l3 00000001 0000011e", w, l, d1, d2);
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
  endtask

  task automatic test_reset_mid_write();
    int e0, r0c, w, l;
    logic [31:0] d1, d2;
    e0 = wr_edges; r0c = rsp0_cnt;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr1 = 5'd7; req0_addr2 = '0; req0_wdata = 32'hAAAA;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_hs got=%b exp=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_reg_read, rf_reg_write,
         rf_write_reg, rf_write_data, rsp_rdata1} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got=%b/%0d/%h/%h exp=0",
        {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_reg_read, rf_reg_write},
        rf_write_reg, rf_write_data, rsp_rdata1);
    end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (wr_edges != e0 || rf[7] !== 32'h107 || rsp0_cnt != r0c) begin
      errors++; $display("FAIL rst_mid_commit got=edges%0d r7=%h rsp0=%0d exp=edges%0d r7=00000107 rsp0=%0d",
        wr_edges, rf[7], rsp0_cnt, e0, r0c);
    end
    txn(1, 1'b0, 5'd7, 5'd0, 32'h0, w, l, d1, d2);
    checks++;
    if (w != 0 || l != 3 || d1 !== 32'h107) begin
      errors++; $display("FAIL rst_mid_next got=w%0d l%0d %h exp=w0 l3 00000107", w, l, d1);
    end
  endtask

  task automatic test_withdraw();
    int e0, r0c, r1c, seen;
    e0 = wr_edges; r0c = rsp0_cnt; r1c = rsp1_cnt; seen = 0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr1 = 5'd9; req1_addr2 = 5'd0;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL wd_req1_hs got=%b exp=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr1 = 5'd9; req0_wdata = 32'hBAD;
    for (int c = 1; c <= 2; c++) begin
      #1; if (req0_ready) seen++;
      step();
    end
    req0_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1; if (req0_ready) seen++;
      step();
    end
    checks++;
    if (seen != 0 || rsp0_cnt != r0c) begin
      errors++; $display("FAIL wd_req0 got=ready%0d rsp0=%0d exp=ready0 rsp0=%0d", seen, rsp0_cnt, r0c);
    end
    checks++;
    if (rsp1_cnt != r1c + 1 || wr_edges != e0 || rf[9] !== 32'h109) begin
      errors++; $display("FAIL wd_effects got=rsp1=%0d edges=%0d r9=%h exp=rsp1=%0d edges=%0d r9=00000109",
        rsp1_cnt, wr_edges, rf[9], r1c + 1, e0);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_write_r0();
    test_back_to_back();
    test_reset_mid_write();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
